// File: rtl/l0_skew_fifo_pkg.sv
// rtl/l0_skew_fifo_pkg.sv - shared defaults and helpers for the input staging buffers
package l0_skew_fifo_pkg;

    localparam int ROW_DEF   = 8;
    localparam int BW_DEF    = 4;
    localparam int DEPTH_DEF = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/l0_skew_fifo_if.sv
// rtl/l0_skew_fifo_if.sv - host write / skewed read bundle of the staging buffer
interface l0_skew_fifo_if
    import l0_skew_fifo_pkg::*;
#(
    parameter int ROW = ROW_DEF,
    parameter int BW  = BW_DEF
);
    logic [ROW*BW-1:0] in;
    logic              wr;
    logic              rd;
    logic              o_full;
    logic              o_ready;
    logic [ROW*BW-1:0] out;
    logic [ROW-1:0]    o_valid;

    modport master (output in, wr, rd, input o_full, o_ready, out, o_valid);
    modport slave  (input in, wr, rd, output o_full, o_ready, out, o_valid);
endinterface

// File: rtl/l0_skew_fifo_row.sv
// rtl/l0_skew_fifo_row.sv - single-row FIFO with registered read data
module fifo_row
    import l0_skew_fifo_pkg::*;
#(
    parameter int bw    = BW_DEF,
    parameter int depth = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic          rd,
    input  logic [bw-1:0] in,
    output logic [bw-1:0] out,
    output logic          full,
    output logic          empty
);
    localparam int AW = clog2(depth);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [bw-1:0] r_out;
    logic [bw-1:0] r_mem [depth];
    logic          w_push;
    logic          w_pop;

    // Extra pointer MSB tells full from empty when the address bits match.
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push = wr & ~full;
    assign w_pop  = rd & ~empty;
    assign out    = r_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_out    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_out    <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in;
        end
    end

endmodule

// File: rtl/l0_skew_fifo.sv
// rtl/l0_skew_fifo.sv - per-row FIFOs popped in a diagonal wave feeding the MAC rows
module l0_skew_fifo
    import l0_skew_fifo_pkg::*;
#(
    parameter int row   = ROW_DEF,
    parameter int bw    = BW_DEF,
    parameter int depth = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    l0_skew_fifo_if.slave  bus
);
    logic [row-1:0]    w_full;
    logic [row-1:0]    w_empty;
    logic [row-1:0]    w_pop_req;
    logic [row*bw-1:0] w_out;
    logic              w_any_full;
    logic              w_push;
    logic [row-1:1]    r_rd_sr;
    logic [row-1:0]    r_valid;

    // o_full comes only from registered pointer state, so rd never unblocks wr in the same cycle.
    assign w_any_full  = |w_full;
    assign w_push      = bus.wr & ~w_any_full;
    assign w_pop_req   = {r_rd_sr, bus.rd};
    assign bus.o_full  = w_any_full;
    assign bus.o_ready = ~w_any_full;
    assign bus.o_valid = r_valid;
    assign bus.out     = w_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_sr <= '0;
            r_valid <= '0;
        end else begin
            r_rd_sr <= w_pop_req[row-2:0];
            r_valid <= w_pop_req & ~w_empty;
        end
    end

    for (genvar g = 0; g < row; g++) begin : g_row
        fifo_row #(
            .bw    (bw),
            .depth (depth)
        ) u_row (
            .clk   (clk),
            .reset (reset),
            .wr    (w_push),
            .rd    (w_pop_req[g]),
            .in    (bus.in[bw*g +: bw]),
            .out   (w_out[bw*g +: bw]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
    end

endmodule

// File: tb/tb_l0_skew_fifo.sv
// tb/tb_l0_skew_fifo.sv - scoreboard bench for the skewed staging FIFO
module tb_l0_skew_fifo;
    import l0_skew_fifo_pkg::*;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l0_skew_fifo_if #(.ROW(ROW), .BW(BW)) bus ();

    l0_skew_fifo #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [BW-1:0]  mq    [ROW][$];
    logic [BW-1:0]  exp_q [ROW][$];
    logic [ROW-1:0] m_sr    = '0;
    logic [ROW-1:0] m_valid = '0;
    logic [ROW-1:0] m_preq  = '0;
    logic           m_full  = 1'b0;
    logic           m_push  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pops use pre-edge occupancy, then the push lands.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROW; r++) begin
                mq[r].delete();
                exp_q[r].delete();
            end
            m_sr    = '0;
            m_valid = '0;
            m_full  = 1'b0;
        end else begin
            m_push = bus.wr && !m_full;
            m_preq = {m_sr[ROW-1:1], bus.rd};
            for (int r = 0; r < ROW; r++) begin
                if (m_preq[r] && mq[r].size() > 0) begin
                    exp_q[r].push_back(mq[r].pop_front());
                    m_valid[r] = 1'b1;
                end else begin
                    m_valid[r] = 1'b0;
                end
            end
            if (m_push) begin
                for (int r = 0; r < ROW; r++) mq[r].push_back(bus.in[BW*r +: BW]);
            end
            m_sr   = {m_preq[ROW-2:0], 1'b0};
            m_full = 1'b0;
            for (int r = 0; r < ROW; r++) if (mq[r].size() == DEPTH) m_full = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
        chk("o_full", 32'(bus.o_full), 32'(m_full));
        chk("o_ready", 32'(bus.o_ready), 32'(!m_full));
        if (!reset) begin
            for (int r = 0; r < ROW; r++) begin
                if (bus.o_valid[r]) begin
                    if (exp_q[r].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_pop row %0d: got %h expected none", r, bus.out[BW*r +: BW]);
                    end else begin
                        chk($sformatf("data_row%0d", r), 32'(bus.out[BW*r +: BW]), 32'(exp_q[r].pop_front()));
                    end
                end
            end
        end
    end

    function automatic logic [ROW*BW-1:0] word(input int k, input int base);
        logic [ROW*BW-1:0] w;
        for (int r = 0; r < ROW; r++) w[BW*r +: BW] = BW'(k + r + base);
        return w;
    endfunction

    task automatic step(input logic w, input logic r, input logic [ROW*BW-1:0] d);
        bus.wr = w;
        bus.rd = r;
        bus.in = d;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0);
    endtask

    logic [7:0] diag [11] = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h38,
                              8'h70, 8'hE0, 8'hC0, 8'h80, 8'h00};

    initial begin
        bus.in = '0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("t1_out", bus.out, 32'h0);
            chk("t1_valid", 32'(bus.o_valid), 32'h0);
        end

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, word(k, 1));
        for (int k = 0; k < 11; k++) begin
            step(1'b0, k < 3, '0);
            chk("t2_diag", 32'(bus.o_valid), 32'(diag[k]));
            if (k == 0) chk("t2_row0_first", 32'(bus.out[3:0]), 32'h1);
        end
        chk("t2_last_words", bus.out, 32'hA9876543);
        idle(2);

        for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, word(k, 0));
        chk("t3_full", 32'(bus.o_full), 32'h1);
        step(1'b1, 1'b0, '1);
        chk("t3_still_full", 32'(bus.o_full), 32'h1);
        for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, '0);
        idle(10);
        chk("t3_drained", 32'(bus.o_full), 32'h0);
        chk("t3_last_words", bus.out, 32'h6543210F);

        step(1'b0, 1'b1, '0);
        idle(10);
        step(1'b1, 1'b0, word(5, 0));
        step(1'b0, 1'b1, '0);
        idle(10);
        chk("t4_word", bus.out, 32'hCBA98765);

        for (int k = 0; k < 200; k++) step(1'b1, 1'b1, word(k, 3));
        idle(12);

        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, word(k, 7));
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("t6_no_wave", 32'(bus.o_valid), 32'h0);
        end
        chk("t6_not_full", 32'(bus.o_full), 32'h0);
        step(1'b0, 1'b1, '0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("t6_empty", 32'(bus.o_valid), 32'h0);
        end

        for (int r = 0; r < ROW; r++) chk($sformatf("pending_row%0d", r), 32'(exp_q[r].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
